// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the
// default iteration count.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam int DIV_ITERS = 32;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one, try to
// subtract the divisor magnitude, keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           borrow;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr_i};
  // A shifted remainder that already spilled into bit WIDTH is always larger
  // than the divisor, so only a set trial MSB without that spill is a borrow.
  assign borrow = trial[WIDTH] & ~rem_sh[WIDTH];

  assign rem_o = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule : div_step

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for the execute stage: quotient on div_lo,
// remainder on div_hi, one has_div pulse per completed divide.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = DIV_ITERS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             has_div,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo
);

  localparam int              CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] v);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_nx),
    .quo_o  (quo_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        // A start coinciding with a flush belongs to a squashed instruction.
        if (start && !flush) begin
          rem_d   = '0;
          quo_d   = mag(is_signed, dividend);
          dvsr_d  = mag(is_signed, divisor);
          q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = is_signed & dividend[WIDTH-1];
          cnt_d   = CNT_LOAD;
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          lo_d    = cond_neg(q_neg_q, quo_q);
          hi_d    = cond_neg(r_neg_q, rem_q);
          state_d = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign has_div = (state_q == DIV_DONE);
  assign div_hi  = hi_q;
  assign div_lo  = lo_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {hi, lo} and due cycle are queued at
// start and compared whenever has_div pulses.
module tb_div_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        has_div;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .has_div   (has_div),
    .div_hi    (div_hi),
    .div_lo    (div_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b, input int due);
    exp_t        e;
    logic [31:0] ma, mb, q, r;
    ma    = (s && a[31]) ? -a : a;
    mb    = (s && b[31]) ? -b : b;
    q     = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
    r     = (mb == 0) ? ma : ma % mb;
    e.lo  = (s && (a[31] ^ b[31])) ? -q : q;
    e.hi  = (s && a[31]) ? -r : r;
    e.due = due;
    return e;
  endfunction

  always @(negedge clock) begin
    if (has_div) begin
      if (sb_q.size() == 0) begin
        chk("spurious_has_div", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("lo", {32'd0, div_lo}, {32'd0, e.lo});
        chk("hi", {32'd0, div_hi}, {32'd0, e.hi});
        chk("latency", 64'(cyc), 64'(e.due));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  // Drives start in the current cycle (cycle 0) and returns in cycle 1.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    @(posedge clock); #1;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    if (expect_result) sb_q.push_back(model(s, a, b, cyc + 34));
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    chk(tag, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int busy_cnt;
    int n;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_has_div", {63'd0, has_div}, 64'd0);
    chk("rst_out", {div_hi, div_lo}, 64'd0);
    #2 reset_n = 1'b1;

    // Unsigned basic, with busy counted across the operation.
    launch(1'b0, 32'd100, 32'd7, 1'b1);
    busy_cnt = 0; n = 0;
    @(negedge clock);
    while (!has_div && n < 100) begin
      if (busy) busy_cnt++;
      n++;
      @(negedge clock);
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    drain("drain_basic");

    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);           drain("drain_sneg");
    launch(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);           drain("drain_sdiv");
    launch(1'b0, 32'd5, 32'd0, 1'b1);                   drain("drain_divu0");
    launch(1'b1, 32'hFFFF_FFF6, 32'd0, 1'b1);           drain("drain_div0");
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   drain("drain_ovf");
    launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);           drain("drain_max");
    launch(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);   drain("drain_bigdiv");

    // Start while busy is ignored.
    launch(1'b0, 32'd1000, 32'd9, 1'b1);
    repeat (9) @(posedge clock); #1;
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    drain("drain_ignore");

    // Back-to-back: second start in the DONE cycle.
    launch(1'b1, 32'hFFFF_FC18, 32'd33, 1'b1);
    repeat (33) @(posedge clock); #1;
    chk("b2b_in_done", {63'd0, has_div}, 64'd1);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd123456; divisor = 32'd789;
    sb_q.push_back(model(1'b0, 32'd123456, 32'd789, cyc + 34));
    @(posedge clock); #1;
    start = 1'b0;
    drain("drain_b2b");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i < 3) ? $urandom_range(1, 1000) : $urandom;
      launch(i[0], a, b, 1'b1);
      drain("drain_rand");
    end

    // Flush in cycle 20: no result, outputs hold the previous one.
    launch(1'b0, 32'd500, 32'd3, 1'b0);
    repeat (18) @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("flush_hold", {div_hi, div_lo}, {last_hi, last_lo});

    // Flush together with start in IDLE drops the start.
    @(posedge clock); #1;
    start = 1'b1; flush = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_start_drop", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-RUN.
    launch(1'b0, 32'd999, 32'd4, 1'b0);
    repeat (10) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_out", {div_hi, div_lo}, 64'd0);
    chk("arst_ctrl", {62'd0, busy, has_div}, 64'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    launch(1'b0, 32'd9, 32'd3, 1'b1);
    drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_unit
